// File: rtl/custom_rptr_empty_if.sv
// custom_rptr_empty_if: read-side FIFO control bundle (read request, synced write pointer input, flags and pointers)
interface custom_rptr_empty_if #(parameter int ADDRSIZE = 4);
    logic                ren;
    logic [ADDRSIZE:0]   wptr_g_i;
    logic                fifo_empty;
    logic                fifo_almost_empty;
    logic [ADDRSIZE-1:0] rd_addr;
    logic [ADDRSIZE:0]   rptr_g;
    logic [ADDRSIZE:0]   rd_level;
    modport master(output ren, wptr_g_i, input fifo_empty, fifo_almost_empty, rd_addr, rptr_g, rd_level);
    modport slave(input ren, wptr_g_i, output fifo_empty, fifo_almost_empty, rd_addr, rptr_g, rd_level);
endinterface

// File: rtl/custom_rptr_empty.sv
// custom_rptr_empty: async FIFO read pointer, empty/almost-empty flags; RPTR_LEVEL_EN builds the rd_level occupancy output
module custom_rptr_empty #(parameter int ADDRSIZE = 4) (
    input logic rclk_i,
    input logic rrst_i,
    custom_rptr_empty_if.slave bus
);
    logic [ADDRSIZE:0] sync1, sync2, rbin_reg, rbin_next, rgray_next;
    logic empty_val, almost_val;
    always_comb begin
        rbin_next  = rbin_reg + (ADDRSIZE+1)'(bus.ren & ~bus.fifo_empty);
        rgray_next = (rbin_next >> 1) ^ rbin_next;
        empty_val  = rgray_next == sync2;
    end
    assign bus.rd_addr = rbin_reg[ADDRSIZE-1:0];
`ifdef RPTR_LEVEL_EN
    logic [ADDRSIZE:0] wbin_sync, level_next;
    always_comb begin
        wbin_sync = '0;
        for (int i = 0; i <= ADDRSIZE; i++) wbin_sync[i] = ^(sync2 >> i);
        level_next = wbin_sync - rbin_next;
        almost_val = empty_val | (level_next == (ADDRSIZE+1)'(1));
    end
    always_ff @(posedge rclk_i) bus.rd_level <= rrst_i ? '0 : level_next;
`else
    logic [ADDRSIZE:0] rbin_plus, rgray_plus;
    // one more read would land exactly on the write pointer: same as level == 1
    always_comb begin
        rbin_plus  = rbin_next + (ADDRSIZE+1)'(1);
        rgray_plus = (rbin_plus >> 1) ^ rbin_plus;
        almost_val = empty_val | (rgray_plus == sync2);
    end
    assign bus.rd_level = '0;
`endif
    always_ff @(posedge rclk_i) begin
        if (rrst_i) begin
            sync1                 <= '0;
            sync2                 <= '0;
            rbin_reg              <= '0;
            bus.rptr_g            <= '0;
            bus.fifo_empty        <= 1'b1;
            bus.fifo_almost_empty <= 1'b1;
        end else begin
            sync1                 <= bus.wptr_g_i;
            sync2                 <= sync1;
            rbin_reg              <= rbin_next;
            bus.rptr_g            <= rgray_next;
            bus.fifo_empty        <= empty_val;
            bus.fifo_almost_empty <= almost_val;
        end
    end
endmodule

// File: tb/tb_custom_rptr_empty.sv
// tb_custom_rptr_empty: table vectors, corner sequences and random traffic against an occupancy-count model
module tb_custom_rptr_empty;
    localparam int A = 4;
`ifdef RPTR_LEVEL_EN
    localparam bit LVL = 1'b1;
`else
    localparam bit LVL = 1'b0;
`endif
    typedef struct {
        bit         r;
        bit         ren;
        logic [4:0] w;
        bit         e;
        bit         a;
        logic [3:0] ad;
        logic [4:0] rp;
        int         lv;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_vec = 0;
    int n_err = 0;
    int m_rd, m_s1, m_s2, m_lvl;
    bit m_empty, m_almost;
    vec_t tbl[$];
    custom_rptr_empty_if #(.ADDRSIZE(A)) bus();
    custom_rptr_empty #(.ADDRSIZE(A)) dut(.rclk_i(clk), .rrst_i(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [4:0] b2g(int b);
        logic [4:0] x;
        x = b[4:0];
        return (x >> 1) ^ x;
    endfunction
    function automatic int g2b(logic [4:0] g);
        int b = 0;
        for (int i = 4; i >= 0; i--) b = b | ((((b >> (i + 1)) & 1) ^ int'(g[i])) << i);
        return b;
    endfunction
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    // model works in plain counts: occupancy = synced write count - read count
    task automatic step(bit r, bit rn, logic [4:0] w);
        rst = r;
        bus.ren = rn;
        bus.wptr_g_i = w;
        @(posedge clk);
        if (r) begin
            m_rd = 0; m_s1 = 0; m_s2 = 0; m_lvl = 0; m_empty = 1; m_almost = 1;
        end else begin
            if (rn && !m_empty) m_rd = (m_rd + 1) % 32;
            m_lvl = (m_s2 - m_rd + 32) % 32;
            m_empty = m_lvl == 0;
            m_almost = m_lvl <= 1;
            m_s2 = m_s1;
            m_s1 = g2b(w);
        end
        #1;
        chk("empty", 32'(bus.fifo_empty), 32'(m_empty));
        chk("almost", 32'(bus.fifo_almost_empty), 32'(m_almost));
        chk("rd_addr", 32'(bus.rd_addr), 32'(m_rd % 16));
        chk("rptr_g", 32'(bus.rptr_g), 32'(b2g(m_rd)));
        chk("rd_level", 32'(bus.rd_level), LVL ? 32'(m_lvl) : 32'd0);
    endtask
    initial begin
        int wc;
        bus.ren = 1'b0;
        bus.wptr_g_i = '0;
        tbl.push_back('{1, 1, 5'b00000, 1, 1, 4'd0, 5'b00000, 0});
        tbl.push_back('{1, 1, 5'b00000, 1, 1, 4'd0, 5'b00000, 0});
        tbl.push_back('{0, 0, 5'b00001, 1, 1, 4'd0, 5'b00000, 0});
        tbl.push_back('{0, 0, 5'b00001, 1, 1, 4'd0, 5'b00000, 0});
        tbl.push_back('{0, 0, 5'b00001, 0, 1, 4'd0, 5'b00000, 1});
        tbl.push_back('{0, 0, 5'b00010, 0, 1, 4'd0, 5'b00000, 1});
        tbl.push_back('{0, 0, 5'b00010, 0, 1, 4'd0, 5'b00000, 1});
        tbl.push_back('{0, 0, 5'b00010, 0, 0, 4'd0, 5'b00000, 3});
        tbl.push_back('{0, 1, 5'b00010, 0, 0, 4'd1, 5'b00001, 2});
        tbl.push_back('{0, 1, 5'b00010, 0, 1, 4'd2, 5'b00011, 1});
        tbl.push_back('{0, 1, 5'b00010, 1, 1, 4'd3, 5'b00010, 0});
        tbl.push_back('{0, 1, 5'b00010, 1, 1, 4'd3, 5'b00010, 0});
        tbl.push_back('{1, 0, 5'b11000, 1, 1, 4'd0, 5'b00000, 0});
        tbl.push_back('{0, 0, 5'b11000, 1, 1, 4'd0, 5'b00000, 0});
        tbl.push_back('{0, 0, 5'b11000, 1, 1, 4'd0, 5'b00000, 0});
        tbl.push_back('{0, 0, 5'b11000, 0, 0, 4'd0, 5'b00000, 16});
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].ren, tbl[i].w);
            chk("tbl_empty", 32'(bus.fifo_empty), 32'(tbl[i].e));
            chk("tbl_almost", 32'(bus.fifo_almost_empty), 32'(tbl[i].a));
            chk("tbl_addr", 32'(bus.rd_addr), 32'(tbl[i].ad));
            chk("tbl_rptr", 32'(bus.rptr_g), 32'(tbl[i].rp));
            chk("tbl_level", 32'(bus.rd_level), LVL ? 32'(tbl[i].lv) : 32'd0);
        end
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 5'b11000);
            if (i == 14) chk("wrap_addr15", 32'(bus.rd_addr), 32'd15);
        end
        chk("wrap_addr", 32'(bus.rd_addr), 32'd0);
        chk("wrap_rptr", 32'(bus.rptr_g), 32'b11000);
        chk("wrap_empty", 32'(bus.fifo_empty), 32'd1);
        chk("wrap_level", 32'(bus.rd_level), 32'd0);
        step(1, 0, 5'b00000);
        for (int i = 0; i < 3; i++) step(0, 0, 5'b01111);
        chk("mid_ready", 32'(bus.fifo_empty), 32'd0);
        for (int i = 0; i < 5; i++) step(0, 1, 5'b01111);
        chk("mid_addr5", 32'(bus.rd_addr), 32'd5);
        step(1, 1, 5'b01111);
        chk("mid_rst_empty", 32'(bus.fifo_empty), 32'd1);
        chk("mid_rst_almost", 32'(bus.fifo_almost_empty), 32'd1);
        chk("mid_rst_addr", 32'(bus.rd_addr), 32'd0);
        chk("mid_rst_rptr", 32'(bus.rptr_g), 32'd0);
        step(0, 0, 5'b01111);
        chk("mid_post1", 32'(bus.fifo_empty), 32'd1);
        step(0, 0, 5'b01111);
        chk("mid_post2", 32'(bus.fifo_empty), 32'd1);
        step(0, 0, 5'b01111);
        chk("mid_post3", 32'(bus.fifo_empty), 32'd0);
        step(1, 0, 5'b00000);
        wc = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                wc = 0;
                step(1, 1'($urandom_range(0, 1)), 5'b00000);
            end else begin
                if ($urandom_range(0, 2) != 0 && (wc - m_rd + 32) % 32 < 16) wc = (wc + 1) % 32;
                step(0, 1'($urandom_range(0, 1)), b2g(wc));
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
